// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter control-state encoding, used by the
// Gray counter, the Gray-to-binary converter and their benches.
package gray_pkg;

  typedef enum logic {
    CNT_IDLE = 1'b0,
    CNT_RUN  = 1'b1
  } cnt_state_e;

  // Helpers work on 32-bit values; callers cast to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Parameterised combinational binary-to-reflected-Gray encoder.
module bin_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// Registered up/down counter with Gray-coded output and wrap pulse.
// Define GRAY_CNT_CHECK_EN to build the sticky single-bit-change checker (err).
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(32'(RST_VAL)));
  localparam logic [WIDTH-1:0] MAX_BIN  = '1;

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             step;
  cnt_state_e       state_q, state_d;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    bin_d   = bin_q;
    wrap_d  = 1'b0;
    step    = 1'b0;
    state_d = CNT_IDLE;
    if (clr) begin
      bin_d = RST_BIN;
    end else if (load) begin
      bin_d = load_val;
    end else if (en) begin
      step    = 1'b1;
      state_d = CNT_RUN;
      if (up_dn) begin
        bin_d  = bin_q + 1'b1;
        wrap_d = (bin_q == MAX_BIN);
      end else begin
        bin_d  = bin_q - 1'b1;
        wrap_d = (bin_q == '0);
      end
    end
  end

  bin_to_gray #(.WIDTH(WIDTH)) u_enc (
    .bin  (bin_d),
    .gray (gray_d)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= RST_BIN;
      gray_q  <= RST_GRAY;
      wrap_q  <= 1'b0;
      state_q <= CNT_IDLE;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      wrap_q  <= wrap_d;
      state_q <= state_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  // RUN means the last edge was a count step; wrap can only follow one.
  assign wrap = wrap_q & (state_q == CNT_RUN);

`ifdef GRAY_CNT_CHECK_EN
  logic [WIDTH-1:0] prev_gray_q;
  logic             err_q;

  // prev_gray holds the code before the last step; after a step gray must differ in one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray_q <= RST_GRAY;
      err_q       <= 1'b0;
    end else begin
      if (clr) begin
        err_q <= 1'b0;
      end else if (state_q == CNT_RUN && $countones(gray_q ^ prev_gray_q) != 1) begin
        err_q <= 1'b1;
      end
      if (clr || load) begin
        prev_gray_q <= gray_d;
      end else if (step) begin
        prev_gray_q <= gray_q;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
